// File: rtl/combo_lock_fsm.sv
// Digit-sequence combination lock.
// One digit is captured per enter strobe. OPEN or ERROR is reported only
// once the full combination has been keyed in, so a wrong digit is never
// revealed early. Consecutive failures are counted, and the lock enters a
// timed LOCKOUT once the retry limit is reached.
module combo_lock_fsm #(
    parameter int                              NUM_DIGITS     = 6,
    parameter int                              DIGIT_W        = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   COMBO          = 24'h305464,
    parameter int                              MAX_TRIES      = 3,
    parameter int                              LOCKOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIGIT_W-1:0]                 digit_in,
    input  logic                               enter,
    input  logic                               relock,
    output logic                               is_open,
    output logic                               is_error,
    output logic                               is_locked,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    digit_count,
    output logic [NUM_DIGITS*DIGIT_W-1:0]      entered,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int DC_W   = $clog2(NUM_DIGITS + 1);
    localparam int FC_W   = $clog2(MAX_TRIES + 1);
    localparam int TM_W   = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_TRIES);
    localparam logic [TM_W-1:0] TM_ONE  = TM_W'(1);
    localparam logic [TM_W-1:0] TM_LOAD = TM_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_ERROR   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t              r_state;
    logic [DC_W-1:0]     r_digit_count;
    logic [CODE_W-1:0]   r_entered;
    logic [FC_W-1:0]     r_fail_count;
    logic [TM_W-1:0]     r_timer;
    logic                r_mismatch;

    state_t              w_state;
    logic [DC_W-1:0]     w_digit_count;
    logic [CODE_W-1:0]   w_entered;
    logic [FC_W-1:0]     w_fail_count;
    logic [TM_W-1:0]     w_timer;
    logic                w_mismatch;

    logic [DIGIT_W-1:0]  w_exp_digit;
    logic                w_digit_ok;

    // Select the combination digit expected at the current entry position.
    always_comb begin
        w_exp_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_count == DC_W'(i)) begin
                w_exp_digit = COMBO[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign w_digit_ok = (digit_in == w_exp_digit);

    // Next-state and next-value logic for every register of the lock.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned, which would infer a latch.
        w_state       = r_state;
        w_digit_count = r_digit_count;
        w_entered     = r_entered;
        w_fail_count  = r_fail_count;
        w_timer       = r_timer;
        w_mismatch    = r_mismatch;

        case (r_state)
            ST_ENTRY: begin
                if (relock) begin
                    // Abort the attempt; it does not count as a failure.
                    w_digit_count = '0;
                    w_entered     = '0;
                    w_mismatch    = 1'b0;
                end else if (enter) begin
                    w_entered     = (r_entered << DIGIT_W) | CODE_W'(digit_in);
                    w_digit_count = r_digit_count + DC_ONE;
                    if (!w_digit_ok) begin
                        w_mismatch = 1'b1;
                    end
                    if (r_digit_count == DC_LAST) begin
                        if (w_digit_ok && !r_mismatch) begin
                            w_state      = ST_OPEN;
                            w_fail_count = '0;
                        end else if (r_fail_count + FC_ONE == FC_MAX) begin
                            w_state      = ST_LOCKOUT;
                            w_timer      = TM_LOAD;
                            w_fail_count = FC_MAX;
                        end else begin
                            w_state      = ST_ERROR;
                            w_fail_count = r_fail_count + FC_ONE;
                        end
                    end
                end
            end

            ST_OPEN: begin
                if (relock) begin
                    w_state       = ST_ENTRY;
                    w_digit_count = '0;
                    w_entered     = '0;
                    w_mismatch    = 1'b0;
                end
            end

            ST_ERROR: begin
                // The digit carried by an enter here is discarded.
                if (relock || enter) begin
                    w_state       = ST_ENTRY;
                    w_digit_count = '0;
                    w_entered     = '0;
                    w_mismatch    = 1'b0;
                end
            end

            ST_LOCKOUT: begin
                // Inputs are ignored; leave on the last cycle of the dwell.
                w_timer = r_timer - TM_ONE;
                if (r_timer <= TM_ONE) begin
                    w_state       = ST_ENTRY;
                    w_digit_count = '0;
                    w_entered     = '0;
                    w_mismatch    = 1'b0;
                    w_fail_count  = '0;
                    w_timer       = '0;
                end
            end

            default: begin
                w_state       = ST_ENTRY;
                w_digit_count = '0;
                w_entered     = '0;
                w_mismatch    = 1'b0;
                w_timer       = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (reset) begin
            r_state       <= ST_ENTRY;
            r_digit_count <= '0;
            r_entered     <= '0;
            r_fail_count  <= '0;
            r_timer       <= '0;
            r_mismatch    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_digit_count <= w_digit_count;
            r_entered     <= w_entered;
            r_fail_count  <= w_fail_count;
            r_timer       <= w_timer;
            r_mismatch    <= w_mismatch;
        end
    end

    assign is_open     = (r_state == ST_OPEN);
    assign is_error    = (r_state == ST_ERROR);
    assign is_locked   = (r_state == ST_LOCKOUT);
    assign digit_count = r_digit_count;
    assign entered     = r_entered;
    assign fail_count  = r_fail_count;

endmodule
